// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding byte requesters into one shared UART transmitter with packet locking.
//   i_clk, i_rst (async, active-high)
//   i_req_valid/i_req_data/i_req_last -> o_req_ready : per-requester byte streams (lane k = bits [8k+7:8k])
//   o_tx_data/o_tx_valid <- i_tx_ready, i_baud_tick : shared transmitter handshake, accepted on tick
//   o_grant : one-hot packet owner, o_timeout : pulse when an idle owner loses its lock
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  input  logic               i_baud_tick,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_timeout
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d;
  logic [7:0]    cnt_q, cnt_d, data_q, data_d;
  logic          last_q, last_d, timeout_q, timeout_d;
  logic [IW-1:0] rr_idx, cand, sel, nxt_ptr;
  logic          rr_hit, xfer, accept;
  logic [7:0]    sel_data, cnt_inc;
  // Scan from the highest offset down so the nearest valid requester at/after ptr wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (i_req_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end
  assign sel         = (state_q == WAIT) ? own_q : rr_idx;
  assign sel_data    = i_req_data[{sel, 3'b000} +: 8];
  assign o_req_ready = i_rst ? '0 :
                       (state_q == IDLE && rr_hit) ? ONE << rr_idx :
                       (state_q == WAIT) ? ONE << own_q : '0;
  assign xfer        = |(i_req_valid & o_req_ready);
  assign accept      = o_tx_valid & i_tx_ready & i_baud_tick;
  assign nxt_ptr     = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
  assign cnt_inc     = cnt_q + 8'd1;
  // ready is never high in SEND and accept only happens in SEND, so the branches are exclusive;
  // a transfer in WAIT outranks a lock expiry on the same edge.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    if (xfer) begin
      data_d  = sel_data;
      last_d  = i_req_last[sel];
      own_d   = sel;
      state_d = SEND;
    end else if (accept) begin
      state_d = last_q ? IDLE : WAIT;
      ptr_d   = last_q ? nxt_ptr : ptr_q;
      cnt_d   = '0;
    end else if (state_q == WAIT && i_baud_tick) begin
      cnt_d = cnt_inc;
      if (cnt_inc == 8'(LOCK_TIMEOUT)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
        ptr_d     = nxt_ptr;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_tx_valid = (state_q == SEND);
  assign o_tx_data  = data_q;
  assign o_grant    = (state_q != IDLE) ? ONE << own_q : '0;
  assign o_timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus random traffic checked against a packet-level model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int LT = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  valid = '0, last = '0;
  logic [8*N-1:0] data = '0;
  logic          txr = 1'b0, tick = 1'b0;
  logic [N-1:0]  ready, grant;
  logic [7:0]    tx_data;
  logic          tx_valid, timeout;
  int checks = 0, failures = 0;
  // model: pending byte, packet owner (-1 = none), pointer, idle ticks, timeout pulse
  bit       m_have, m_last, m_to;
  logic [7:0] m_data;
  int       m_own, m_ptr, m_idle;
  int       order[$];
  uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data), .i_req_last(last),
    .o_req_ready(ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(txr),
    .i_baud_tick(tick), .o_grant(grant), .o_timeout(timeout));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction
  task automatic m_reset();
    m_have = 0; m_last = 0; m_to = 0; m_data = '0; m_own = -1; m_ptr = 0; m_idle = 0;
  endtask
  function automatic logic [N-1:0] m_ready();
    if (rst || m_have) return '0;
    if (m_own >= 0) return N'(1) << m_own;
    for (int i = 0; i < N; i++) if (valid[(m_ptr + i) % N]) return N'(1) << ((m_ptr + i) % N);
    return '0;
  endfunction
  task automatic m_update();
    logic [N-1:0] r;
    int k;
    r = m_ready();
    m_to = 0;
    if (m_have) begin
      if (txr && tick) begin
        m_have = 0;
        if (m_last) begin m_ptr = (m_own + 1) % N; m_own = -1; end
        else m_idle = 0;
      end
    end else if (|(r & valid)) begin
      k = idx_of(r & valid);
      m_own = k; m_have = 1; m_data = data[8*k +: 8]; m_last = last[k];
    end else if (m_own >= 0 && tick) begin
      m_idle++;
      if (m_idle == LT) begin m_to = 1; m_ptr = (m_own + 1) % N; m_own = -1; end
    end
  endtask
  task automatic compare();
    if (rst) m_reset();
    chk("tx_valid", 32'(tx_valid), 32'(m_have));
    if (m_have) chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("grant", 32'(grant), m_own >= 0 ? 32'(1) << m_own : 32'd0);
    chk("ready", 32'(ready), 32'(m_ready()));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask
  // called just after a negedge with inputs already set; returns at the next negedge
  task automatic step();
    #1 compare();
    @(posedge clk);
    if (rst) m_reset(); else m_update();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_timeout", 32'(timeout), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    m_reset();
    #1 do_reset();
    // single byte
    valid = 4'b0001; data = 32'h61; last = 4'b0001;
    #1 chk("t1_ready", 32'(ready), 32'b0001);
    step();
    valid = '0;
    #1 chk("t1_txv", 32'(tx_valid), 1);
    chk("t1_data", 32'(tx_data), 32'h61);
    chk("t1_grant", 32'(grant), 32'b0001);
    step(); step();
    txr = 1; tick = 1; step();
    txr = 0; tick = 0;
    #1 chk("t1_txv_done", 32'(tx_valid), 0);
    chk("t1_grant_done", 32'(grant), 0);
    chk("t1_ptr", m_ptr, 1);
    // fairness from ptr 0
    do_reset();
    valid = '1; last = '1; data = 32'h44332211; txr = 1; tick = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_valid) order.push_back(idx_of(grant));
    end
    chk("fair_len", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("fair_order", order[i], i % 4);
    // packet lock: req2 three bytes while req1 waits
    do_reset();
    valid = 4'b0100; last = '0; data = 32'h00A00000; txr = 1; tick = 1;
    step();
    valid = 4'b0110; data = 32'h00A10000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin data = 32'h00A20000; last = 4'b0100; end
      #1 chk("lock_req1_ready", 32'(ready[1]), 0);
      step();
    end
    #1 chk("lock_grant_free", 32'(grant), 0);
    chk("lock_req1_turn", 32'(ready), 32'b0010);
    valid = '0; last = '0;
    // timeout: ptr now 3, req3 sends a non-last byte then idles
    valid = 4'b1000; data = 32'h33000000; step();
    valid = '0; step();
    for (int i = 0; i < 8; i++) begin
      tick = (i % 2 == 0);
      #1 if (i == 7) begin
        chk("to_pulse", 32'(timeout), 1);
        chk("to_grant", 32'(grant), 0);
      end else begin
        chk("to_nopulse", 32'(timeout), 0);
        chk("to_held", 32'(grant), 32'b1000);
      end
      step();
    end
    tick = 0;
    #1 chk("to_pulse_end", 32'(timeout), 0);
    chk("to_ptr", m_ptr, 0);
    valid = '1;
    #1 chk("to_next", 32'(ready), 32'b0001);
    // backpressure
    valid = 4'b0001; data = 32'h5A; last = 4'b0001; txr = 0; step();
    valid = '0; tick = 1;
    for (int i = 0; i < 50; i++) begin
      data = $urandom;
      step();
      chk("bp_data", 32'(tx_data), 32'h5A);
    end
    txr = 1; step();
    #1 chk("bp_done", 32'(tx_valid), 0);
    // reset while in WAIT with requests pending
    valid = 4'b0100; last = '0; step(); step();
    valid = 4'b0111;
    #1 chk("wait_before_rst", 32'(grant), 32'b0100);
    do_reset();
    #1 chk("post_rst_ready", 32'(ready), 32'b0001);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      valid = N'($urandom);
      data  = $urandom;
      last  = N'($urandom);
      txr   = ($urandom_range(0, 9) < 7);
      tick  = ($urandom_range(0, 1) == 1);
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 16, giving the baud ticks an idle packet owner may hold the grant (1..255).
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  input  N_REQ  per-requester byte-available flags.
REQ-006 i_req_data  input  8*N_REQ  per-requester bytes; requester k occupies bits [8k+7:8k].
REQ-007 i_req_last  input  N_REQ  per-requester end-of-packet flag, qualified by i_req_valid.
REQ-008 o_req_ready  output  N_REQ  per-requester pop strobe; a byte transfers on a clock edge where valid[k]&&ready[k].
REQ-009 o_tx_data  output  8  byte presented to the shared UART transmitter.
REQ-010 o_tx_valid  output  1  byte-present flag to the transmitter.
REQ-011 i_tx_ready  input  1  transmitter idle flag.
REQ-012 i_baud_tick  input  1  baud-rate enable shared with the transmitter.
REQ-013 o_grant  output  N_REQ  one-hot current owner; all zero when no owner.
REQ-014 o_timeout  output  1  one-cycle pulse when a lock is released by timeout.

Function
REQ-015 The block SHALL implement states IDLE, SEND, WAIT.
REQ-016 A byte SHALL count as accepted by the transmitter on a clock edge where o_tx_valid && i_tx_ready && i_baud_tick.
REQ-017 In IDLE, o_req_ready SHALL be one-hot on the requester selected round-robin: first k with i_req_valid[k] high, searching from pointer ptr upward and wrapping modulo N_REQ; all zero if no request.
REQ-018 On that transfer edge the block SHALL latch data and last, set o_grant to the winner, set o_tx_valid=1, and enter SEND; o_tx_valid SHALL rise one clock after the request is seen.
REQ-019 In SEND, o_tx_data and o_tx_valid SHALL hold stable, and o_req_ready SHALL be zero, until acceptance.
REQ-020 On acceptance with latched last=1, the block SHALL clear o_tx_valid and o_grant, set ptr to (grant index+1) mod N_REQ, and enter IDLE.
REQ-021 On acceptance with latched last=0, the block SHALL clear o_tx_valid, keep o_grant, clear the lock counter, and enter WAIT.
REQ-022 In WAIT, o_req_ready SHALL be high only for the granted requester; other requesters SHALL be ignored.
REQ-023 In WAIT, on transfer, the block SHALL latch data and last, set o_tx_valid=1, and return to SEND.
REQ-024 In WAIT without transfer, the 8-bit lock counter SHALL increment on each i_baud_tick.
REQ-025 If the counter would reach LOCK_TIMEOUT, the block SHALL instead clear o_grant, advance ptr past the owner, pulse o_timeout for one cycle, and enter IDLE.
REQ-026 A transfer in the same cycle as timeout expiry SHALL take priority: no timeout, enter SEND.
REQ-027 i_req_valid dropping while not ready SHALL have no effect; a latched byte SHALL never be discarded except by reset.
REQ-028 o_tx_valid SHALL be asserted only in SEND.
REQ-029 o_grant SHALL be non-zero only in SEND and WAIT.

Reset
REQ-030 While i_rst is high: state=IDLE, ptr=0, lock counter=0, o_tx_valid=0, o_tx_data=0, o_grant=0, o_timeout=0, o_req_ready=0.
REQ-031 Reset mid-packet or mid-SEND SHALL drop the latched byte and lock with no further output.

Verification
REQ-032 Single byte: req0 valid, data 0x61, last=1 -> next cycle o_tx_valid=1, o_tx_data=0x61, grant=0001; after tick with ready -> valid=0, grant=0, ptr=1.
REQ-033 Fairness: all four valid with last=1 continuously -> bytes sent in grant order 0,1,2,3,0; no requester sent twice before others.
REQ-034 Packet lock: req2 sends 3 bytes, last on third, while req1 is valid -> req1 sees no ready until req2's third byte is accepted.
REQ-035 Timeout: req3 sends a byte with last=0, then stays idle; LOCK_TIMEOUT=4 -> after the 4th baud tick in WAIT, o_timeout pulses once, grant=0, ptr=0.
REQ-036 Backpressure: i_tx_ready=0 for 50 ticks while in SEND -> o_tx_data and o_tx_valid stable; byte accepted on first tick with ready=1.
REQ-037 Reset in WAIT with requests pending -> all outputs zero; first post-reset grant goes to lowest-index valid requester.
